// File: rtl/bcd_countdown_timer.sv
// BCD mm:ss down-counter with tick prescaler, saturating load, terminal-count
// pulse and optional auto-reload; feeds the seven-segment display drivers.
module bcd_countdown_timer #(
  parameter int MIN_DIGITS  = 2,
  parameter int TICK_DIV    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                    clock,
  input  logic                    clr,
  input  logic                    loadn,
  input  logic [3:0]              data_sec_ones,
  input  logic [3:0]              data_sec_tens,
  input  logic [4*MIN_DIGITS-1:0] data_mins,
  input  logic                    enable,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    done,
  output logic                    running
);
  localparam int MW = 4 * MIN_DIGITS;
  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t          state_q, state_d;
  logic [3:0]      sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
  logic [MW-1:0]   mins_q, mins_d;
  logic [3:0]      rl_ones_q, rl_ones_d, rl_tens_q, rl_tens_d;
  logic [MW-1:0]   rl_mins_q, rl_mins_d;
  logic [15:0]     presc_q, presc_d;
  logic            done_q, done_d;

  logic [3:0]      ld_ones, ld_tens, dec_ones, dec_tens;
  logic [MW-1:0]   ld_mins, dec_mins;
  logic [MIN_DIGITS-1:0] borrow;
  logic            tick, dec_zero, ld_nonzero;

  assign zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (mins_q == '0);

  assign ld_ones = (data_sec_ones > 4'd9) ? 4'd9 : data_sec_ones;
  assign ld_tens = (data_sec_tens > 4'd5) ? 4'd5 : data_sec_tens;
  assign ld_nonzero = (ld_ones != 4'd0) || (ld_tens != 4'd0) || (ld_mins != '0);

  // Seconds borrow chain; borrow[0] is the carry into the minutes LSD.
  assign dec_ones  = (sec_ones_q == 4'd0) ? 4'd9 : sec_ones_q - 4'd1;
  assign dec_tens  = (sec_ones_q != 4'd0) ? sec_tens_q :
                     (sec_tens_q == 4'd0) ? 4'd5 : sec_tens_q - 4'd1;
  assign borrow[0] = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0);

  for (genvar gi = 0; gi < MIN_DIGITS; gi++) begin : g_min_digit
    logic [3:0] din, cur;
    assign din = data_mins[4*gi +: 4];
    assign cur = mins_q[4*gi +: 4];
    assign ld_mins[4*gi +: 4]  = (din > 4'd9) ? 4'd9 : din;
    assign dec_mins[4*gi +: 4] = !borrow[gi] ? cur :
                                 (cur == 4'd0) ? 4'd9 : cur - 4'd1;
    if (gi < MIN_DIGITS - 1) begin : g_borrow
      assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
    end
  end

  assign dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == '0);
  // Never count from all-zero, so the top minute digit cannot underflow.
  assign tick = (state_q == RUN) && enable && (presc_q == PRESC_MAX) && !zero;

  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    mins_d     = mins_q;
    rl_ones_d  = rl_ones_q;
    rl_tens_d  = rl_tens_q;
    rl_mins_d  = rl_mins_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    if (!loadn) begin
      sec_ones_d = ld_ones;
      sec_tens_d = ld_tens;
      mins_d     = ld_mins;
      rl_ones_d  = ld_ones;
      rl_tens_d  = ld_tens;
      rl_mins_d  = ld_mins;
      presc_d    = 16'd0;
      state_d    = ld_nonzero ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE, EXPIRED: ;
        RUN: begin
          if (zero) begin
            // Only reachable in auto-reload mode: the cycle after done.
            if (AUTO_RELOAD) begin
              sec_ones_d = rl_ones_q;
              sec_tens_d = rl_tens_q;
              mins_d     = rl_mins_q;
              presc_d    = 16'd0;
            end else begin
              state_d = EXPIRED;
            end
          end else if (tick) begin
            presc_d    = 16'd0;
            sec_ones_d = dec_ones;
            sec_tens_d = dec_tens;
            mins_d     = dec_mins;
            if (dec_zero) begin
              done_d = 1'b1;
              if (!AUTO_RELOAD) state_d = EXPIRED;
            end
          end else if (enable) begin
            presc_d = presc_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      mins_q     <= '0;
      rl_ones_q  <= 4'd0;
      rl_tens_q  <= 4'd0;
      rl_mins_q  <= '0;
      presc_q    <= 16'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      mins_q     <= mins_d;
      rl_ones_q  <= rl_ones_d;
      rl_tens_q  <= rl_tens_d;
      rl_mins_q  <= rl_mins_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign mins     = mins_q;
  assign done     = done_q;
  assign running  = (state_q == RUN);
endmodule
